// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: iterative AES SubBytes / InvSubBytes engine.
// LANES S-box lanes substitute LANES bytes per cycle; a 128-bit block
// takes 16/LANES RUN cycles and is then held in DONE until consumed.

// One substitution lane: shared GF(2^8) inverter wrapped by the forward
// affine (SubBytes) or preceded by the inverse affine (InvSubBytes).
module sbox_lane (
  input  logic       mode,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8), and maps 0 to 0 without a special case
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] r;
    t = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
  endfunction

  logic [7:0] inv_in;
  logic [7:0] inv_out;

  // Direction steering around the single inverter
  always_comb begin
    inv_in  = mode ? inv_affine(din) : din;
    inv_out = gf_inv(inv_in);
    dout    = mode ? inv_out : affine(inv_out);
  end

endmodule

module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int BEATS = 16 / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mode_q, mode_d;
  // Packed so byte 0 (state MSB) sits in beat BEATS-1; beat cnt is
  // therefore slot LAST-cnt. Lane order inside a beat is irrelevant
  // because every byte of the beat is substituted together.
  logic [BEATS-1:0][LANES-1:0][7:0] work_q, work_d;
  logic [LANES-1:0][7:0] lane_in, lane_out;
  logic [CW-1:0] beat_sel;

  assign beat_sel = LAST - cnt_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .mode (mode_q),
      .din  (lane_in[l]),
      .dout (lane_out[l])
    );
  end

  // Pick the beat currently being substituted
  always_comb begin
    lane_in = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_sel == CW'(b)) lane_in = work_q[b];
    end
  end

  // Next-state, beat counter and working-register update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int b = 0; b < BEATS; b++) begin
          if (beat_sel == CW'(b)) work_d[b] = lane_out;
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign state_out = work_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: three instances (LANES 4, 1, 16), a
// table-driven S-box model built by brute-force GF search, a per-cycle
// compare process, and directed vectors with literal expectations.
module tb_sub_bytes_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] iv, ir, md, orr, ov, bs;
  logic [2:0][127:0] si, so;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LN = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    sub_bytes_engine #(.LANES(LN)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(iv[g]), .in_ready(ir[g]), .mode(md[g]), .state_in(si[g]),
      .out_valid(ov[g]), .out_ready(orr[g]), .state_out(so[g]), .busy(bs[g])
    );
  end

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL0     = 128'h0;
  localparam logic [127:0] ALL63    = {16{8'h63}};
  localparam logic [127:0] ALL52    = {16{8'h52}};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int beats_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 16 : 1);
  endfunction

  task automatic chk(input string nm, input int i, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got=%h want=%h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm, input int i);
    checks++;
    errors++;
    $display("FAIL %s inst%0d timed out t=%0t", nm, i, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb [256];
  logic [7:0] isb[256];

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, b, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int k = 0; k < 8; k++)
        b[k] = inv[k] ^ inv[(k+4)%8] ^ inv[(k+5)%8] ^ inv[(k+6)%8] ^ inv[(k+7)%8] ^ c[k];
      sb[x] = b;
      isb[b] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic m);
    logic [127:0] r;
    logic [7:0] by;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      by = d[127-8*k -: 8];
      r[127-8*k -: 8] = m ? isb[by] : sb[by];
    end
    return r;
  endfunction

  // ---------------- per-cycle compare ----------------
  logic [2:0] outst = '0;
  int acc_e[3];
  logic [127:0] expd[3];

  // Block-level view: a block is outstanding from acceptance until its
  // output handshake; its result is due BEATS edges after acceptance.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        outst[i] = 1'b0;
        chk("rst_in_ready", i, 128'(ir[i]), 128'(1));
        chk("rst_out_valid", i, 128'(ov[i]), 128'(0));
        chk("rst_busy", i, 128'(bs[i]), 128'(0));
        chk("rst_state_out", i, so[i], ALL0);
      end else begin
        logic e_ir, e_ov;
        e_ir = !outst[i];
        e_ov = outst[i] && (cyc >= acc_e[i] + beats_of(i));
        chk("in_ready", i, 128'(ir[i]), 128'(e_ir));
        chk("out_valid", i, 128'(ov[i]), 128'(e_ov));
        chk("busy", i, 128'(bs[i]), 128'(outst[i]));
        if (e_ov) chk("state_out", i, so[i], expd[i]);
        if (e_ir && iv[i]) begin
          outst[i] = 1'b1;
          acc_e[i] = cyc + 1;
          expd[i]  = model(si[i], md[i]);
        end else if (e_ov && orr[i]) begin
          outst[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_accept(input int i, output bit got);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = ir[i];
      @(posedge clk);
      #1;
    end
    if (!got) timeout("accept", i);
  endtask

  task automatic wait_out(input int i, input int t0, input int lat);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = ov[i];
    end
    if (!got) timeout("out_valid", i);
    else chk("latency", i, 128'(cyc - t0), 128'(lat));
  endtask

  // Caller is just past a rising edge. Mode and data are scrambled right
  // after acceptance to show they are only sampled at the handshake.
  task automatic send(input int i, input logic m, input logic [127:0] d,
                      input logic [127:0] exp, input int lat, input int hold);
    bit got;
    int t0;
    orr[i] = (hold == 0);
    iv[i] = 1'b1; md[i] = m; si[i] = d;
    wait_accept(i, got);
    iv[i] = 1'b0; md[i] = ~m; si[i] = ~d;
    t0 = cyc;
    if (got) begin
      wait_out(i, t0, lat);
      chk("result", i, so[i], exp);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk("hold_data", i, so[i], exp);
        chk("hold_in_ready", i, 128'(ir[i]), 128'(0));
      end
    end
    orr[i] = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bit got;
    int t0;
    iv = '0; md = '0; orr = '1;
    si = '0;
    build_tables();
    chk("model_sb00", 0, 128'(sb[8'h00]), 128'(8'h63));
    chk("model_sb53", 0, 128'(sb[8'h53]), 128'(8'hed));
    chk("model_sb01", 0, 128'(sb[8'h01]), 128'(8'h7c));
    chk("model_isb63", 0, 128'(isb[8'h63]), 128'(8'h00));
    chk("model_fips", 0, model(FIPS_IN, 1'b0), FIPS_OUT);

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // LANES=4
    send(0, 1'b0, FIPS_IN, FIPS_OUT, 4, 0);
    send(0, 1'b1, FIPS_OUT, FIPS_IN, 4, 0);
    send(0, 1'b0, ALL0, ALL63, 4, 0);
    send(0, 1'b1, ALL0, ALL52, 4, 0);
    send(0, 1'b1, ALL63, ALL0, 4, 0);
    send(0, 1'b0, FIPS_IN, FIPS_OUT, 4, 5);
    // LANES=1
    send(1, 1'b0, ALL0, ALL63, 16, 0);
    send(1, 1'b1, ALL0, ALL52, 16, 0);
    send(1, 1'b1, ALL63, ALL0, 16, 0);
    send(1, 1'b1, FIPS_OUT, FIPS_IN, 16, 0);
    // LANES=16
    send(2, 1'b0, ALL0, ALL63, 1, 0);
    send(2, 1'b1, ALL0, ALL52, 1, 0);
    send(2, 1'b1, ALL63, ALL0, 1, 0);
    send(2, 1'b0, FIPS_IN, FIPS_OUT, 1, 0);

    // Backpressure with a second block pending on the input
    orr[0] = 1'b0;
    iv[0] = 1'b1; md[0] = 1'b0; si[0] = ALL0;
    wait_accept(0, got);
    si[0] = ALL63; md[0] = 1'b1;
    t0 = cyc;
    wait_out(0, t0, 4);
    chk("bp_first", 0, so[0], ALL63);
    for (int h = 0; h < 5; h++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", 0, so[0], ALL63);
      chk("bp_hold_in_ready", 0, 128'(ir[0]), 128'(0));
    end
    orr[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after", 0, 128'(ir[0]), 128'(1));
    wait_accept(0, got);
    iv[0] = 1'b0;
    t0 = cyc;
    if (got) begin
      wait_out(0, t0, 4);
      chk("bp_second", 0, so[0], ALL0);
    end
    @(posedge clk); #1;

    // Asynchronous reset at RUN beat 2
    iv[0] = 1'b1; md[0] = 1'b0; si[0] = FIPS_IN;
    wait_accept(0, got);
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_in_ready", 0, 128'(ir[0]), 128'(1));
    chk("arst_out_valid", 0, 128'(ov[0]), 128'(0));
    chk("arst_busy", 0, 128'(bs[0]), 128'(0));
    chk("arst_state_out", 0, so[0], ALL0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    send(0, 1'b1, FIPS_OUT, FIPS_IN, 4, 0);
    send(0, 1'b0, ALL0, ALL63, 4, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
